// File: rtl/cordic_vectoring_atan.sv
// Iterative vectoring-mode CORDIC: converts a Cartesian vector (x, y) into
// its principal angle atan(y/x) in Q2.20 radians and its gain-scaled
// magnitude. One micro-rotation per clock, 16 iterations per job.
module cordic_vectoring_atan #(
  parameter int WIDTH      = 22,
  parameter int ITERATIONS = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] x_in,
  input  logic [WIDTH-1:0] y_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] angle_out,
  output logic [WIDTH+1:0] mag_out,
  output logic             x_neg,
  output logic             zero_vec
);

  localparam int XW = WIDTH + 2;
  localparam int CW = $clog2(ITERATIONS);

  typedef enum logic {
    IDLE,
    ITER
  } state_t;

  state_t state_q, state_d;

  logic signed [XW-1:0]    x_q, y_q;
  logic signed [WIDTH-1:0] z_q;
  logic [CW-1:0]           cnt_q;
  logic                    xneg_q, zero_q;

  logic                    accept, last;
  logic signed [XW-1:0]    x_ext, y_ext, x_load, y_load;
  logic signed [XW-1:0]    x_sh, y_sh, x_nx, y_nx;
  logic signed [WIDTH-1:0] atan_i, z_nx;

  // Arctangent table, atan(2^-i) in Q2.20.
  always_comb begin
    atan_i = '0;
    case (cnt_q)
      4'd0:  atan_i = WIDTH'(20'hC90FD);
      4'd1:  atan_i = WIDTH'(20'h76B19);
      4'd2:  atan_i = WIDTH'(20'h3EB6E);
      4'd3:  atan_i = WIDTH'(20'h1FD5B);
      4'd4:  atan_i = WIDTH'(20'h0FFAA);
      4'd5:  atan_i = WIDTH'(20'h07FF5);
      4'd6:  atan_i = WIDTH'(20'h03FFE);
      4'd7:  atan_i = WIDTH'(20'h01FFF);
      4'd8:  atan_i = WIDTH'(20'h00FFF);
      4'd9:  atan_i = WIDTH'(20'h007FF);
      4'd10: atan_i = WIDTH'(20'h003FF);
      4'd11: atan_i = WIDTH'(20'h001FF);
      4'd12: atan_i = WIDTH'(20'h000FF);
      4'd13: atan_i = WIDTH'(20'h0007F);
      4'd14: atan_i = WIDTH'(20'h0003F);
      4'd15: atan_i = WIDTH'(20'h0001F);
      default: atan_i = '0;
    endcase
  end

  // Input fold into the right half-plane; sign-extend before negating so
  // that -2.0 becomes +2.0 without wrapping.
  always_comb begin
    x_ext  = {{2{x_in[WIDTH-1]}}, x_in};
    y_ext  = {{2{y_in[WIDTH-1]}}, y_in};
    x_load = x_ext;
    y_load = y_ext;
    if (x_in[WIDTH-1]) begin
      x_load = -x_ext;
      y_load = -y_ext;
    end
  end

  // One micro-rotation driving y toward zero; x and y use their old values.
  always_comb begin
    x_sh = x_q >>> cnt_q;
    y_sh = y_q >>> cnt_q;
    x_nx = x_q;
    y_nx = y_q;
    z_nx = z_q;
    if (!y_q[XW-1]) begin
      x_nx = x_q + y_sh;
      y_nx = y_q - x_sh;
      z_nx = z_q + atan_i;
    end else begin
      x_nx = x_q - y_sh;
      y_nx = y_q + x_sh;
      z_nx = z_q - atan_i;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic: accept in IDLE, leave ITER after the final iteration.
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    last    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          accept  = 1'b1;
          state_d = ITER;
        end
      end
      ITER: begin
        if (cnt_q == CW'(ITERATIONS - 1)) begin
          last    = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Datapath and result registers; outputs change only on done or reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      x_q       <= '0;
      y_q       <= '0;
      z_q       <= '0;
      cnt_q     <= '0;
      xneg_q    <= 1'b0;
      zero_q    <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      angle_out <= '0;
      mag_out   <= '0;
      x_neg     <= 1'b0;
      zero_vec  <= 1'b0;
    end else begin
      done <= 1'b0;
      if (accept) begin
        x_q    <= x_load;
        y_q    <= y_load;
        z_q    <= '0;
        cnt_q  <= '0;
        xneg_q <= x_in[WIDTH-1];
        zero_q <= (x_in == '0) && (y_in == '0);
        busy   <= 1'b1;
      end else if (state_q == ITER) begin
        x_q   <= x_nx;
        y_q   <= y_nx;
        z_q   <= z_nx;
        cnt_q <= cnt_q + 1'b1;
        if (last) begin
          angle_out <= zero_q ? '0 : z_nx;
          mag_out   <= zero_q ? '0 : unsigned'(x_nx);
          x_neg     <= xneg_q;
          zero_vec  <= zero_q;
          done      <= 1'b1;
          busy      <= 1'b0;
        end
      end
    end
  end

endmodule
